// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with optional signed saturation.
// The carry chain is cut into SEG_W-bit segments, one segment resolved per stage.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    // WIDTH must be a multiple of SEG_W.
    localparam int STAGES = WIDTH / SEG_W;

    logic             adv;
    logic [WIDTH-1:0] fin_sum;
    logic [WIDTH-1:0] sat_sum;
    logic             fin_cout;
    logic             fin_ovf;
    logic             fin_valid;
    logic             fin_sat;
    logic             a_msb;
    logic             b_msb;

    // The whole pipe moves as one: any stall at the output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage gi sees the operand bits not yet consumed (RW wide), the carry into
    // its segment and the low sum bits already resolved by earlier stages.
    for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
        localparam int RW = WIDTH - gi * SEG_W;
        localparam int DW = (gi + 1) * SEG_W;

        logic [RW-1:0]  a;
        logic [RW-1:0]  b;
        logic           c;
        logic           sat;
        logic           v;
        logic [SEG_W:0] seg;
        logic [DW-1:0]  s_nx;

        assign seg = {1'b0, a[SEG_W-1:0]} + {1'b0, b[SEG_W-1:0]} + {{SEG_W{1'b0}}, c};

        if (gi == 0) begin : g_in
            assign a    = in_a;
            assign b    = in_b ^ {WIDTH{in_sub}};
            assign c    = in_sub;
            assign sat  = in_sat;
            assign v    = in_valid;
            assign s_nx = seg[SEG_W-1:0];
        end else begin : g_reg
            logic [gi*SEG_W-1:0] s;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v <= 1'b0;
                end else if (adv) begin
                    v <= stage_g[gi-1].v;
                end
            end

            // Payload needs no reset: it is only ever qualified by v.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a   <= stage_g[gi-1].a[RW+SEG_W-1:SEG_W];
                    b   <= stage_g[gi-1].b[RW+SEG_W-1:SEG_W];
                    c   <= stage_g[gi-1].seg[SEG_W];
                    sat <= stage_g[gi-1].sat;
                    s   <= stage_g[gi-1].s_nx;
                end
            end

            assign s_nx = {seg[SEG_W-1:0], s};
        end
    end

    assign fin_sum   = stage_g[STAGES-1].s_nx;
    assign fin_cout  = stage_g[STAGES-1].seg[SEG_W];
    assign fin_valid = stage_g[STAGES-1].v;
    assign fin_sat   = stage_g[STAGES-1].sat;
    assign a_msb     = stage_g[STAGES-1].a[SEG_W-1];
    assign b_msb     = stage_g[STAGES-1].b[SEG_W-1];

    // b_msb is already inverted for subtraction, so one rule covers both modes.
    assign fin_ovf = (a_msb == b_msb) && (fin_sum[WIDTH-1] != a_msb);

    always_comb begin
        sat_sum = fin_sum;
        if (fin_sat && fin_ovf) begin
            sat_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= fin_valid;
            out_sum   <= sat_sum;
            out_cout  <= fin_cout;
            out_ovf   <= fin_ovf;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: driver pushes expected results on accept,
// an independent monitor pops and compares on every output transfer.
module tb_addsub_pipe;

    localparam int WIDTH   = 16;
    localparam int SEG_W   = 4;
    localparam int LAT_EDG = WIDTH / SEG_W - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    addsub_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          stall_req = 0;
    int          stall_seen = 0;
    bit          rnd_ready = 0;
    bit          lat_chk   = 0;
    bit          held      = 0;
    logic [15:0] held_sum;
    logic        held_cout;
    logic        held_ovf;
    int          n_out = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Signed-integer reference, independent of any segment structure.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic sat);
        exp_t e;
        int   sa;
        int   sb;
        int   r;
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        r      = sub ? sa - sb : sa + sb;
        e.ovf  = (r > 32767) || (r < -32768);
        e.cout = sub ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 17'h0FFFF);
        if (sat && r > 32767)       e.sum = 16'h7FFF;
        else if (sat && r < -32768) e.sum = 16'h8000;
        else                        e.sum = r[15:0];
        e.acc  = 0;
        return e;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic sat, input logic [15:0] es, input logic ec, input logic eo);
        int   budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_sat   = sat;
        #1;
        while (!in_ready) begin
            budget++;
            if (budget > 200) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.acc  = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_req > 0) begin
                out_ready = 1'b0;
                stall_req--;
            end else if (rnd_ready) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: samples after both input drivers have settled for the cycle.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(out_sum), 32'(held_sum));
                chk("hold_flags", {30'd0, out_cout, out_ovf}, {30'd0, held_cout, held_ovf});
            end
            held = 0;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                stall_seen++;
                held      = 1;
                held_sum  = out_sum;
                held_cout = out_cout;
                held_ovf  = out_ovf;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    $display("out #%0d: sum=%h cout=%0d ovf=%0d (exp %h %0d %0d)",
                             n_out, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                    chk("sum", 32'(out_sum), 32'(e.sum));
                    chk("cout", 32'(out_cout), 32'(e.cout));
                    chk("ovf", 32'(out_ovf), 32'(e.ovf));
                    if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'(LAT_EDG));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    vec_t vecs[14];

    initial begin
        exp_t        m;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rsub;
        logic        rsat;
        logic [15:0] corner[5];

        vecs[0]  = '{16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0};
        vecs[1]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[7]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
        vecs[10] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[12] = '{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[13] = '{16'hF0F0, 16'h0F10, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};

        corner[0] = 16'h0000;
        corner[1] = 16'h0001;
        corner[2] = 16'h7FFF;
        corner[3] = 16'h8000;
        corner[4] = 16'hFFFF;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_sub   = 1'b0;
        in_sat   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_flags", {30'd0, out_cout, out_ovf}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, back to back, no stalls: exact latency checked.
        lat_chk = 1;
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sat,
                 vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end
        drain();
        lat_chk = 0;

        // Eight beats with a three-cycle output stall in the middle.
        stall_seen = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'(16'h1000 * i + i), 16'h0101, 1'b0, 1'b0,
                 16'(16'h1000 * i + i + 16'h0101), 1'b0, 1'b0);
            if (i == 4) stall_req = 3;
        end
        drain();
        chk("stall_cycles", 32'(stall_seen), 32'd3);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            send(16'h0100, 16'(i), 1'b0, 1'b0, 16'(16'h0100 + i), 1'b0, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_flight", 32'(dut.stage_g[1].v | dut.stage_g[2].v | dut.stage_g[3].v), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        lat_chk = 1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        drain();
        lat_chk = 0;

        // Random operands and flow control against the reference model.
        rnd_ready = 1;
        for (int i = 0; i < 3000; i++) begin
            ra   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            rsub = 1'($urandom_range(0, 1));
            rsat = 1'($urandom_range(0, 1));
            m    = model(ra, rb, rsub, rsat);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(ra, rb, rsub, rsat, m.sum, m.cout, m.ovf);
        end
        drain();
        rnd_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
